// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the successive-approximation ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    DONE
  } sar_state_t;

  // Bits needed to hold any count 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Reset-to-zero flop chain that brings the asynchronous comparator output into clk.
module sar_cmp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: sample, then one DAC trial per bit from MSB down,
// deciding each bit from the synchronized comparator at the end of its trial window.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int TRIAL_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX      = (SAMPLE_CYCLES > TRIAL_CYCLES) ? SAMPLE_CYCLES : TRIAL_CYCLES;
  localparam int CNT_W        = cnt_width(CNT_MAX);
  localparam int IDX_W        = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIAL_LAST  = CNT_W'(TRIAL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             cmp_s;
  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] kept;

  sar_cmp_sync #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk(clk),
    .rst(rst),
    .d_i(cmp_i),
    .q_o(cmp_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= IDX_MSB;
      dac_q    <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dac_q    <= dac_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dac_d     = dac_q;
    data_d    = data_q;
    sample_d  = sample_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    trial_bit = WIDTH'(1) << idx_q;
    kept      = cmp_s ? dac_q : (dac_q & ~trial_bit);

    // Abort wins over every other transition, including the final bit decision.
    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      idx_d    = IDX_MSB;
      dac_d    = '0;
      sample_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = SAMPLE;
            cnt_d    = '0;
            idx_d    = IDX_MSB;
            dac_d    = '0;
            sample_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            state_d  = TRIAL;
            cnt_d    = '0;
            sample_d = 1'b0;
            dac_d    = MSB_CODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TRIAL: begin
          if (cnt_q == TRIAL_LAST) begin
            cnt_d = '0;
            if (idx_q != '0) begin
              idx_d = idx_q - IDX_W'(1);
              dac_d = kept | (trial_bit >> 1);
            end else begin
              state_d = DONE;
              dac_d   = kept;
              data_d  = kept;
              valid_d = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = IDX_MSB;
          dac_d   = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sample_o   = sample_q;
  assign dac_code_o = dac_q;
  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

endmodule
